// File: rtl/c4_pattern_tx.sv
// Serial pattern source for the C4 detector: sends a latched WIDTH-bit word MSB-first,
// repeated `reps` times with a one-cycle zero gap, then pulses done for one cycle.
module c4_pattern_tx #(
  parameter int WIDTH  = 8,
  parameter int REPS_W = 4
) (
  input  logic              n_clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  pattern,
  input  logic [REPS_W-1:0] reps,
  output logic              a,
  output logic              busy,
  output logic              done,
  output logic [REPS_W-1:0] rep_left
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t            state, state_nx;
  logic [WIDTH-1:0]  sh, sh_nx;
  logic [WIDTH-1:0]  pat_q, pat_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [REPS_W-1:0] rep_nx;

  always_ff @(negedge n_clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      sh       <= '0;
      pat_q    <= '0;
      cnt      <= '0;
      rep_left <= '0;
    end else begin
      state    <= state_nx;
      sh       <= sh_nx;
      pat_q    <= pat_nx;
      cnt      <= cnt_nx;
      rep_left <= rep_nx;
    end
  end

  always_comb begin
    state_nx = state;
    sh_nx    = sh;
    pat_nx   = pat_q;
    cnt_nx   = cnt;
    rep_nx   = rep_left;
    case (state)
      IDLE: begin
        if (start) begin
          pat_nx   = pattern;
          sh_nx    = pattern;
          rep_nx   = reps;
          cnt_nx   = CNT_TOP;
          state_nx = (reps != '0) ? SEND : DONE;
        end
      end
      SEND: begin
        sh_nx = {sh[WIDTH-2:0], 1'b0};
        if (cnt != '0) begin
          cnt_nx = cnt - 1'b1;
        end else begin
          rep_nx = rep_left - 1'b1;
          // rep_left==1 here means the word just finished was the last one
          if (rep_left != REPS_W'(1)) begin
            sh_nx    = pat_q;
            cnt_nx   = CNT_TOP;
            state_nx = GAP;
          end else begin
            state_nx = DONE;
          end
        end
      end
      GAP:     state_nx = SEND;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign a    = (state == SEND) & sh[WIDTH-1];
  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_c4_pattern_tx.sv
// Bench for c4_pattern_tx: per-cycle expected outputs come from a queue built
// directly from the pattern/reps rules; inputs change and outputs are sampled on rising n_clk.
module tb_c4_pattern_tx;
  localparam int WIDTH  = 8;
  localparam int REPS_W = 4;

  logic              n_clk;
  logic              rst;
  logic              start;
  logic [WIDTH-1:0]  pattern;
  logic [REPS_W-1:0] reps;
  logic              a, busy, done;
  logic [REPS_W-1:0] rep_left;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic              a;
    logic              busy;
    logic              done;
    logic [REPS_W-1:0] rl;
  } exp_t;

  exp_t q[$];

  c4_pattern_tx #(.WIDTH(WIDTH), .REPS_W(REPS_W)) dut (
    .n_clk   (n_clk),
    .rst     (rst),
    .start   (start),
    .pattern (pattern),
    .reps    (reps),
    .a       (a),
    .busy    (busy),
    .done    (done),
    .rep_left(rep_left)
  );

  initial begin
    n_clk = 1'b1;
    forever #5 n_clk = ~n_clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".a"},        {31'd0, a},        32'd0);
    check({tag, ".busy"},     {31'd0, busy},     32'd0);
    check({tag, ".done"},     {31'd0, done},     32'd0);
    check({tag, ".rep_left"}, {28'd0, rep_left}, 32'd0);
  endtask

  // Expected waveform: every repetition emits the word MSB-first, gaps sit
  // between repetitions only, and a single DONE cycle closes the transfer.
  task automatic build_model(input logic [WIDTH-1:0] p, input int r);
    exp_t e;
    q.delete();
    for (int k = 0; k < r; k++) begin
      for (int b = WIDTH - 1; b >= 0; b--) begin
        e.a = p[b]; e.busy = 1'b1; e.done = 1'b0; e.rl = REPS_W'(r - k);
        q.push_back(e);
      end
      if (k < r - 1) begin
        e.a = 1'b0; e.busy = 1'b1; e.done = 1'b0; e.rl = REPS_W'(r - k - 1);
        q.push_back(e);
      end
    end
    e.a = 1'b0; e.busy = 1'b1; e.done = 1'b1; e.rl = '0;
    q.push_back(e);
  endtask

  // Called at a rising edge while the DUT is idle; returns at a rising edge in IDLE.
  task automatic do_xfer(input string tag, input logic [WIDTH-1:0] p, input int r, input bit noise);
    exp_t e;
    int   n;
    build_model(p, r);
    n = q.size();
    start   = 1'b1;
    pattern = p;
    reps    = REPS_W'(r);
    for (int i = 0; i < n; i++) begin
      @(posedge n_clk);
      e = q.pop_front();
      check($sformatf("%s.a[%0d]", tag, i),    {31'd0, a},        {31'd0, e.a});
      check($sformatf("%s.busy[%0d]", tag, i), {31'd0, busy},     {31'd0, e.busy});
      check($sformatf("%s.done[%0d]", tag, i), {31'd0, done},     {31'd0, e.done});
      check($sformatf("%s.rl[%0d]", tag, i),   {28'd0, rep_left}, {28'd0, e.rl});
      if (noise) begin
        start   = 1'($urandom);
        pattern = WIDTH'($urandom);
        reps    = REPS_W'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    @(posedge n_clk);
    check_idle({tag, ".idle"});
    start = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b1;
    pattern = 8'hA5;
    reps    = 4'd3;

    // asynchronous reset with start held high: reset wins
    #10 rst = 1'b0;
    #1  check_idle("reset_async");
    repeat (3) begin
      @(posedge n_clk);
      check_idle("reset_hold");
    end
    start = 1'b0;
    rst   = 1'b1;
    @(posedge n_clk);
    check_idle("post_reset");

    do_xfer("single_b2", 8'b1011_0010, 1, 1'b0);
    do_xfer("rep3_c3",   8'hC3,        3, 1'b0);
    do_xfer("zero_reps", 8'h5A,        0, 1'b0);
    do_xfer("max_reps",  8'h81,       15, 1'b1);

    // abort mid-transfer: inputs wiggle during SEND, then reset in bit 4
    start   = 1'b1;
    pattern = 8'hFF;
    reps    = 4'd2;
    for (int i = 0; i < 3; i++) begin
      @(posedge n_clk);
      check($sformatf("abort.a[%0d]", i),    {31'd0, a},        32'd1);
      check($sformatf("abort.busy[%0d]", i), {31'd0, busy},     32'd1);
      check($sformatf("abort.rl[%0d]", i),   {28'd0, rep_left}, 32'd2);
      start   = ~start;
      pattern = 8'h00;
      reps    = 4'd7;
    end
    @(posedge n_clk);
    check("abort.a[3]", {31'd0, a}, 32'd1);
    #1 rst = 1'b0;
    #1 check_idle("abort_now");
    repeat (3) begin
      @(posedge n_clk);
      check_idle("abort_hold");
    end
    start = 1'b0;
    rst   = 1'b1;
    @(posedge n_clk);
    check_idle("abort_release");

    // random transfers, some back-to-back, some with idle gaps and input noise
    for (int t = 0; t < 8; t++) begin
      logic [WIDTH-1:0] rp;
      int               rr;
      rp = WIDTH'($urandom);
      rr = $urandom_range(0, 15);
      repeat ($urandom_range(0, 2)) begin
        @(posedge n_clk);
        check_idle($sformatf("rnd_gap%0d", t));
      end
      do_xfer($sformatf("rnd%0d", t), rp, rr, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
